// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard detection for the register-read stage,
// backed by a shift-register scoreboard of in-flight writes. Option: FWD_R0_HARDWIRED_EN.
module fwd_hazard_unit #(
   parameter int REG_AW   = 3,
   parameter int DEPTH    = 3,
   parameter int LOAD_LAT = 2,
   localparam int SELW    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              adv,
   input  logic              iss_valid,
   input  logic              iss_wr,
   input  logic              iss_load,
   input  logic [REG_AW-1:0] iss_rd,
   input  logic [REG_AW-1:0] rs1,
   input  logic [REG_AW-1:0] rs2,
   input  logic              rs1_used,
   input  logic              rs2_used,
   input  logic [DEPTH-1:0]  flush_mask,
   output logic [SELW-1:0]   fwd_a_sel,
   output logic [SELW-1:0]   fwd_b_sel,
   output logic              stall,
   output logic [7:0]        stall_cnt
);

   logic [DEPTH:1]              sb_v;
   logic [DEPTH:1]              sb_wr;
   logic [DEPTH:1]              sb_ld;
   logic [DEPTH:1][REG_AW-1:0]  sb_rd;

   logic req_a;
   logic req_b;

   // Scan oldest to youngest so the youngest matching producer is the one left standing.
   function automatic logic [SELW:0] lookup(
      input logic [REG_AW-1:0]             src,
      input logic                          used,
      input logic [DEPTH:1]                v_q,
      input logic [DEPTH:1]                wr_q,
      input logic [DEPTH:1]                ld_q,
      input logic [DEPTH:1][REG_AW-1:0]    rd_q
   );
      logic [SELW-1:0] sel;
      logic            req;
      logic            hit;
      sel = '0;
      req = 1'b0;
      for (int k = DEPTH; k >= 1; k--) begin
         hit = v_q[k] & wr_q[k] & used & (rd_q[k] == src);
`ifdef FWD_R0_HARDWIRED_EN
         hit = hit & (src != '0);
`endif
         if (hit) begin
            if (ld_q[k] && (k < LOAD_LAT)) begin
               sel = '0;
               req = 1'b1;
            end else begin
               sel = SELW'(k);
               req = 1'b0;
            end
         end
      end
      return {req, sel};
   endfunction

   always_comb begin
      {req_a, fwd_a_sel} = lookup(rs1, rs1_used, sb_v, sb_wr, sb_ld, sb_rd);
      {req_b, fwd_b_sel} = lookup(rs2, rs2_used, sb_v, sb_wr, sb_ld, sb_rd);
      stall = (req_a | req_b) & iss_valid;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sb_v      <= '0;
         sb_wr     <= '0;
         sb_ld     <= '0;
         sb_rd     <= '0;
         stall_cnt <= '0;
      end else begin
         if (adv) begin
            // Flush acts on the pre-shift position, so the killed entry lands one stage older.
            for (int k = DEPTH; k >= 2; k--) begin
               sb_v[k]  <= sb_v[k-1] & ~flush_mask[k-2];
               sb_wr[k] <= sb_wr[k-1];
               sb_ld[k] <= sb_ld[k-1];
               sb_rd[k] <= sb_rd[k-1];
            end
            sb_v[1]  <= iss_valid & ~stall;
            sb_wr[1] <= iss_wr;
            sb_ld[1] <= iss_load;
            sb_rd[1] <= iss_rd;
         end else begin
            sb_v <= sb_v & ~flush_mask;
         end

         if (stall) begin
            if (stall_cnt != 8'hFF) begin
               stall_cnt <= stall_cnt + 8'd1;
            end
         end else begin
            stall_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: directed scenarios with fixed expectations
// plus randomized traffic checked against an in-flight instruction list model.
module tb_fwd_hazard_unit;

   localparam int REG_AW   = 3;
   localparam int DEPTH    = 3;
   localparam int LOAD_LAT = 2;
   localparam int SELW     = $clog2(DEPTH + 1);

`ifdef FWD_R0_HARDWIRED_EN
   localparam bit R0_HARD = 1'b1;
   localparam int R0_EXP  = 0;
`else
   localparam bit R0_HARD = 1'b0;
   localparam int R0_EXP  = 1;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              adv;
   logic              iss_valid;
   logic              iss_wr;
   logic              iss_load;
   logic [REG_AW-1:0] iss_rd;
   logic [REG_AW-1:0] rs1;
   logic [REG_AW-1:0] rs2;
   logic              rs1_used;
   logic              rs2_used;
   logic [DEPTH-1:0]  flush_mask;
   logic [SELW-1:0]   fwd_a_sel;
   logic [SELW-1:0]   fwd_b_sel;
   logic              stall;
   logic [7:0]        stall_cnt;

   fwd_hazard_unit #(.REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .adv(adv), .iss_valid(iss_valid), .iss_wr(iss_wr),
      .iss_load(iss_load), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used),
      .rs2_used(rs2_used), .flush_mask(flush_mask), .fwd_a_sel(fwd_a_sel),
      .fwd_b_sel(fwd_b_sel), .stall(stall), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int a;
      int b;
      bit s;
      int c;
   } exp_t;

   typedef struct {
      bit v;
      bit wr;
      bit ld;
      int rd;
   } ent_t;

   exp_t q[$];
   ent_t m[DEPTH];   // m[0] is the youngest in-flight instruction
   int   m_cnt = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic void look(input int s, input bit used, output int sel, output bit req);
      sel = 0;
      req = 1'b0;
      if (!used) return;
      if (R0_HARD && s == 0) return;
      for (int i = 0; i < DEPTH; i++) begin
         if (m[i].v && m[i].wr && m[i].rd == s) begin
            if (m[i].ld && (i + 1) < LOAD_LAT) req = 1'b1;
            else sel = i + 1;
            return;
         end
      end
   endfunction

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input bit w, input bit l, input int rd, input int r1,
                        input int r2, input bit u1, input bit u2, input int fm,
                        input bit a, input bit rn);
      iss_valid  = v;
      iss_wr     = w;
      iss_load   = l;
      iss_rd     = REG_AW'(rd);
      rs1        = REG_AW'(r1);
      rs2        = REG_AW'(r2);
      rs1_used   = u1;
      rs2_used   = u2;
      flush_mask = DEPTH'(fm);
      adv        = a;
      rst_n      = rn;
   endtask

   // Push this cycle's expectation (fixed values when dir=1, model otherwise), then advance the model.
   task automatic chk(input bit dir, input int ea, input int eb, input bit es, input int ec);
      int   sa, sb;
      bit   ra, rb, st;
      exp_t e;
      look(int'(rs1), rs1_used, sa, ra);
      look(int'(rs2), rs2_used, sb, rb);
      st = (ra || rb) && iss_valid;
      if (dir) e = '{ea, eb, es, ec};
      else     e = '{sa, sb, st, m_cnt};
      q.push_back(e);
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
         m_cnt = 0;
      end else begin
         for (int i = 0; i < DEPTH; i++) if (flush_mask[i]) m[i].v = 1'b0;
         if (adv) begin
            for (int i = DEPTH - 1; i >= 1; i--) m[i] = m[i-1];
            m[0] = '{iss_valid && !st, iss_wr, iss_load, int'(iss_rd)};
         end
         m_cnt = st ? ((m_cnt < 255) ? m_cnt + 1 : 255) : 0;
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp += 4;
            if (int'(fwd_a_sel) != e.a) begin
               n_bad++;
               $display("FAIL fwd_a_sel: got %0d expected %0d at %0t", fwd_a_sel, e.a, $time);
            end
            if (int'(fwd_b_sel) != e.b) begin
               n_bad++;
               $display("FAIL fwd_b_sel: got %0d expected %0d at %0t", fwd_b_sel, e.b, $time);
            end
            if (stall != e.s) begin
               n_bad++;
               $display("FAIL stall: got %0d expected %0d at %0t", stall, e.s, $time);
            end
            if (int'(stall_cnt) != e.c) begin
               n_bad++;
               $display("FAIL stall_cnt: got %0d expected %0d at %0t", stall_cnt, e.c, $time);
            end
         end
      end
   end

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      next_cyc();

      // reset state with sources in use
      drive(0, 0, 0, 0, 3, 5, 1, 1, 0, 1, 1);                  chk(1, 0, 0, 0, 0);

      // ADD rd=4 walking through stages 1..3 then retiring
      next_cyc(); drive(1, 1, 0, 4, 0, 0, 0, 0, 0, 1, 1);     chk(1, 0, 0, 0, 0);
      next_cyc(); drive(1, 0, 0, 0, 4, 0, 1, 0, 0, 1, 1);     chk(1, 1, 0, 0, 0);
      next_cyc();                                             chk(1, 2, 0, 0, 0);
      next_cyc();                                             chk(1, 3, 0, 0, 0);
      next_cyc();                                             chk(1, 0, 0, 0, 0);

      // load-use: one stall cycle, then forward from stage 2
      next_cyc(); drive(1, 1, 1, 2, 0, 0, 0, 0, 0, 1, 1);     chk(1, 0, 0, 0, 0);
      next_cyc(); drive(1, 0, 0, 0, 0, 2, 0, 1, 0, 1, 1);     chk(1, 0, 0, 1, 0);
      next_cyc();                                             chk(1, 0, 2, 0, 1);
      next_cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);     chk(1, 0, 0, 0, 0);

      // youngest producer wins
      next_cyc(); drive(1, 1, 0, 6, 0, 0, 0, 0, 0, 1, 1);     chk(1, 0, 0, 0, 0);
      next_cyc();                                             chk(1, 0, 0, 0, 0);
      next_cyc(); drive(1, 0, 0, 0, 6, 0, 1, 0, 0, 1, 1);     chk(1, 1, 0, 0, 0);

      // flushed stage-1 producer no longer forwards
      next_cyc(); drive(1, 1, 0, 7, 0, 0, 0, 0, 0, 1, 1);     chk(1, 0, 0, 0, 0);
      next_cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);     chk(1, 0, 0, 0, 0);
      next_cyc(); drive(1, 0, 0, 0, 7, 0, 1, 0, 0, 1, 1);     chk(1, 0, 0, 0, 0);

      // register 0 producer
      next_cyc(); drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);     chk(1, 0, 0, 0, 0);
      next_cyc(); drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1);     chk(1, R0_EXP, 0, 0, 0);

      // stall persists while the pipeline is frozen
      next_cyc(); drive(1, 1, 1, 3, 0, 0, 0, 0, 0, 1, 1);     chk(1, 0, 0, 0, 0);
      next_cyc(); drive(1, 0, 0, 0, 3, 0, 1, 0, 0, 0, 1);     chk(1, 0, 0, 1, 0);
      next_cyc();                                             chk(1, 0, 0, 1, 1);
      next_cyc(); drive(1, 0, 0, 0, 3, 0, 1, 0, 0, 1, 1);     chk(1, 0, 0, 1, 2);
      next_cyc();                                             chk(1, 2, 0, 0, 3);
      next_cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);     chk(1, 0, 0, 0, 0);

      // reset in the middle of a stall drops the hazard
      next_cyc(); drive(1, 1, 1, 5, 0, 0, 0, 0, 0, 1, 1);     chk(1, 0, 0, 0, 0);
      next_cyc(); drive(1, 0, 0, 0, 5, 0, 1, 0, 0, 1, 0);     chk(1, 0, 0, 1, 0);
      next_cyc(); drive(1, 0, 0, 0, 5, 0, 1, 0, 0, 1, 1);     chk(1, 0, 0, 0, 0);

      // stall counter saturation
      next_cyc(); drive(1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1);     chk(0, 0, 0, 0, 0);
      for (int i = 0; i < 260; i++) begin
         next_cyc(); drive(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1);  chk(0, 0, 0, 0, 0);
      end
      next_cyc();                                             chk(1, 0, 0, 1, 255);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         next_cyc();
         drive(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 3) == 0,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), ($urandom % 4) != 0, ($urandom % 2) == 0,
               (($urandom % 6) == 0) ? int'($urandom % 8) : 0,
               ($urandom % 5) != 0, ($urandom % 100) != 0);
         chk(0, 0, 0, 0, 0);
      end

      @(negedge clk);
      #1;
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
